stock_counter_bcd: RTL and testbench

- Parametrised successor to the cap-dispenser stock counter.
- Counts remaining units from debounced "cap" (Tampar) and "add" (adicionar) buttons, with a refill budget, saturating arithmetic and optional automatic refill at a low-stock threshold.
- Produces a binary count and an N-digit BCD/7-segment display through a sequential double-dabble converter.
- Sits between the raw push-buttons and the display pins.

---
 rtl/stock_counter_bcd.sv | 261 ++++++++++++++++++++++++++
 tb/tb_stock_counter_bcd.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stock_counter_bcd.sv
// Stock counter for the cap dispenser. Debounced cap/add buttons feed a saturating counter
// with a refill budget, and a sequential double-dabble converter drives a BCD/7-seg display.

module stock_counter_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] run;

    // The level flips only after DEB_CYCLES consecutive disagreeing samples; the pulse marks a rising flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            run   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            pulse <= 1'b0;
            if (s2 == level) begin
                run <= '0;
            end else if (run == CW'(DEB_CYCLES - 1)) begin
                level <= s2;
                run   <= '0;
                pulse <= s2;
            end else begin
                run <= run + CW'(1);
            end
        end
    end
endmodule

module stock_counter_bcd #(
    parameter int WIDTH        = 8,
    parameter int DIGITS       = 2,
    parameter int INIT_COUNT   = 15,
    parameter int REFILL       = 15,
    parameter int MAX_COUNT    = 99,
    parameter int REFILL_LIMIT = 3,
    parameter int LOW_THRESH   = 5,
    parameter int AUTO_REFILL  = 1,
    parameter int DEB_CYCLES   = 4
) (
    input  logic                               CK,
    input  logic                               ini,
    input  logic                               Tampar,
    input  logic                               adicionar,
    output logic [WIDTH-1:0]                   count,
    output logic [4*DIGITS-1:0]                bcd,
    output logic [7*DIGITS-1:0]                seg,
    output logic                               bcd_valid,
    output logic                               TemR,
    output logic                               low_stock,
    output logic [$clog2(REFILL_LIMIT+1)-1:0]  refills_left,
    output logic                               err
);
    localparam int RW = $clog2(REFILL_LIMIT + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    logic             cap_p;
    logic             add_p;
    logic             auto_pend;
    logic             refill_req;
    logic             refill_ok;
    logic             cap_zero;
    logic [WIDTH:0]   wide_sum;
    logic [WIDTH:0]   wide_cap;
    logic [WIDTH-1:0] count_next;
    logic             auto_next;
    logic             err_next;

    conv_state_t      state;
    conv_state_t      state_next;
    logic [WIDTH-1:0] conv_src;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    acc;
    logic [SW-1:0]    step;
    logic             pending;
    logic             valid_q;
    logic             changed;
    logic             load;
    logic             shift_en;
    logic             publish;

    stock_counter_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_cap_deb (
        .clk   (CK),
        .rst   (ini),
        .raw   (Tampar),
        .pulse (cap_p)
    );

    stock_counter_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_add_deb (
        .clk   (CK),
        .rst   (ini),
        .raw   (adicionar),
        .pulse (add_p)
    );

    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] v);
        logic [WIDTH-1:0] r;
        if (v > (WIDTH+1)'(MAX_COUNT)) r = WIDTH'(MAX_COUNT);
        else                           r = v[WIDTH-1:0];
        return r;
    endfunction

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // A cap and an accepted refill in the same cycle combine; auto refill only follows a plain cap.
    always_comb begin
        refill_req = add_p | auto_pend;
        refill_ok  = refill_req && (refills_left != '0);
        cap_zero   = (count == '0);
        wide_sum   = {1'b0, count} + (WIDTH+1)'(REFILL);
        wide_cap   = wide_sum - (WIDTH+1)'(1);
        count_next = count;
        auto_next  = 1'b0;
        if (refill_ok && cap_p) begin
            count_next = sat(wide_cap);
        end else if (refill_ok) begin
            count_next = sat(wide_sum);
        end else if (cap_p && !cap_zero) begin
            count_next = count - WIDTH'(1);
            auto_next  = (AUTO_REFILL != 0) && (count_next == WIDTH'(LOW_THRESH));
        end
        err_next = (refill_req && !refill_ok) || (cap_p && cap_zero && !refill_ok);
    end

    always_ff @(posedge CK) begin
        if (ini) begin
            count        <= WIDTH'(INIT_COUNT);
            refills_left <= RW'(REFILL_LIMIT);
            err          <= 1'b0;
            auto_pend    <= 1'b0;
        end else begin
            count     <= count_next;
            err       <= err_next;
            auto_pend <= auto_next;
            if (refill_ok) refills_left <= refills_left - RW'(1);
        end
    end

    assign TemR      = (count != '0);
    assign low_stock = (count <= WIDTH'(LOW_THRESH));

    always_ff @(posedge CK) begin
        if (ini) state <= IDLE;
        else     state <= state_next;
    end

    // The first shift happens on the load cycle so a fresh count is published WIDTH+1 cycles later.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        publish    = 1'b0;
        changed    = (count != conv_src);
        case (state)
            IDLE: begin
                if (pending || changed) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (changed) begin
                    load = 1'b1;
                end else begin
                    shift_en = 1'b1;
                    if (step == SW'(WIDTH - 1)) state_next = DONE;
                end
            end
            DONE: begin
                if (changed) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    publish    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (ini) begin
            conv_src <= '0;
            shreg    <= '0;
            acc      <= '0;
            step     <= '0;
            pending  <= 1'b1;
            valid_q  <= 1'b0;
            bcd      <= '0;
        end else begin
            if (load) begin
                conv_src <= count;
                acc      <= {{(BW-1){1'b0}}, count[WIDTH-1]};
                shreg    <= count << 1;
                step     <= SW'(1);
                pending  <= 1'b0;
                valid_q  <= 1'b0;
            end else if (shift_en) begin
                {acc, shreg} <= {add3(acc), shreg} << 1;
                step         <= step + SW'(1);
            end
            if (publish) begin
                bcd     <= acc;
                valid_q <= 1'b1;
            end
        end
    end

    // A stale result must never look valid, even in the cycle the count moves.
    assign bcd_valid = valid_q && !changed;

    always_comb begin
        seg = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = seg7(bcd[4*i +: 4]);
        end
    end
endmodule

// File: tb/tb_stock_counter_bcd.sv
// Bench for stock_counter_bcd: two builds (auto refill on / off, saturating start) share the buttons
// and are checked against an arithmetic model of the stock rules.

module tb_stock_counter_bcd;
    logic CK = 1'b0;
    logic ini = 1'b1;
    logic Tampar = 1'b0;
    logic adicionar = 1'b0;

    logic [7:0]  cntS   [2];
    logic [7:0]  bcdS   [2];
    logic [13:0] segS   [2];
    logic        validS [2];
    logic        temrS  [2];
    logic        lowS   [2];
    logic        errS   [2];
    logic [1:0]  refS   [2];

    int passed = 0;
    int total = 0;
    int errSeen [2] = '{0, 0};
    int expErr  [2] = '{0, 0};
    int mCount  [2];
    int mRef    [2];
    bit mAuto   [2];
    bit autoSeen;
    logic [6:0] segTab [10];
    logic [7:0] oldB   [2];

    always #5 CK = ~CK;

    stock_counter_bcd dut0 (
        .CK(CK), .ini(ini), .Tampar(Tampar), .adicionar(adicionar),
        .count(cntS[0]), .bcd(bcdS[0]), .seg(segS[0]), .bcd_valid(validS[0]),
        .TemR(temrS[0]), .low_stock(lowS[0]), .refills_left(refS[0]), .err(errS[0])
    );

    stock_counter_bcd #(.INIT_COUNT(90), .AUTO_REFILL(0)) dut1 (
        .CK(CK), .ini(ini), .Tampar(Tampar), .adicionar(adicionar),
        .count(cntS[1]), .bcd(bcdS[1]), .seg(segS[1]), .bcd_valid(validS[1]),
        .TemR(temrS[1]), .low_stock(lowS[1]), .refills_left(refS[1]), .err(errS[1])
    );

    // Count every cycle each build shows an error pulse.
    always @(negedge CK) begin
        for (int d = 0; d < 2; d++) begin
            if (errS[d] === 1'b1) errSeen[d]++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] bcdOf(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [13:0] segOf(input int v);
        return {segTab[v / 10], segTab[v % 10]};
    endfunction

    task automatic modelReset();
        mCount[0] = 15;
        mCount[1] = 90;
        for (int d = 0; d < 2; d++) begin
            mRef[d]  = 3;
            mAuto[d] = 1'b0;
        end
    endtask

    // One clock of stock rules: refill requests merge, saturate at 99, cap-to-5 arms auto refill on build 0.
    task automatic modelStep(input bit cap, input bit add);
        for (int d = 0; d < 2; d++) begin
            bit req;
            bit ok;
            bit e;
            req = add || mAuto[d];
            mAuto[d] = 1'b0;
            ok = req && (mRef[d] > 0);
            e = req && !ok;
            if (ok) begin
                mCount[d] = mCount[d] + 15 - (cap ? 1 : 0);
                if (mCount[d] > 99) mCount[d] = 99;
                mRef[d]--;
            end else if (cap) begin
                if (mCount[d] == 0) begin
                    e = 1'b1;
                end else begin
                    mCount[d]--;
                    if (d == 0 && mCount[d] == 5) begin
                        mAuto[d] = 1'b1;
                        autoSeen = 1'b1;
                    end
                end
            end
            if (e) expErr[d]++;
        end
    endtask

    task automatic checkState(input string stage);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s count[%0d]", stage, d), cntS[d], mCount[d]);
            checkOutput($sformatf("%s refills[%0d]", stage, d), refS[d], mRef[d]);
            checkOutput($sformatf("%s TemR[%0d]", stage, d), temrS[d], (mCount[d] != 0));
            checkOutput($sformatf("%s low[%0d]", stage, d), lowS[d], (mCount[d] <= 5));
        end
    endtask

    task automatic checkConv(input string stage);
        for (int i = 0; i < 40 && !(validS[0] === 1'b1 && validS[1] === 1'b1); i++) @(negedge CK);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s valid[%0d]", stage, d), validS[d], 1);
            checkOutput($sformatf("%s bcd[%0d]", stage, d), bcdS[d], bcdOf(mCount[d]));
            checkOutput($sformatf("%s seg[%0d]", stage, d), segS[d], segOf(mCount[d]));
        end
    endtask

    task automatic checkErrs(input string stage);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s errs[%0d]", stage, d), errSeen[d], expErr[d]);
        end
    endtask

    // One clean press: the pulse lands 7 clocks after the raw edge, any auto refill one clock later.
    task automatic applyStimulus(input bit cap, input bit add, input string stage);
        int hold;
        int rel;
        hold = int'($urandom_range(9, 11));
        rel  = int'($urandom_range(8, 10));
        Tampar = cap;
        adicionar = add;
        repeat (6) @(negedge CK);
        checkState({stage, " pre"});
        @(negedge CK);
        modelStep(cap, add);
        checkState({stage, " edge7"});
        @(negedge CK);
        modelStep(1'b0, 1'b0);
        checkState({stage, " edge8"});
        repeat (hold - 8) @(negedge CK);
        Tampar = 1'b0;
        adicionar = 1'b0;
        repeat (rel) @(negedge CK);
        checkState({stage, " settled"});
        checkErrs(stage);
        checkConv(stage);
    endtask

    initial begin
        int sel;
        segTab[0] = 7'h3F; segTab[1] = 7'h06; segTab[2] = 7'h5B; segTab[3] = 7'h4F;
        segTab[4] = 7'h66; segTab[5] = 7'h6D; segTab[6] = 7'h7D; segTab[7] = 7'h07;
        segTab[8] = 7'h7F; segTab[9] = 7'h6F;

        // Reset and first conversion timing.
        modelReset();
        repeat (3) @(negedge CK);
        checkState("reset");
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset valid[%0d]", d), validS[d], 0);
            checkOutput($sformatf("reset bcd[%0d]", d), bcdS[d], 0);
            checkOutput($sformatf("reset err[%0d]", d), errS[d], 0);
        end
        ini = 1'b0;
        repeat (8) @(negedge CK);
        for (int d = 0; d < 2; d++) checkOutput($sformatf("startup early valid[%0d]", d), validS[d], 0);
        @(negedge CK);
        for (int d = 0; d < 2; d++) checkOutput($sformatf("startup valid[%0d]", d), validS[d], 1);
        checkConv("startup");

        // Chatter shorter than the debounce window, then a clean hold.
        for (int i = 0; i < 3; i++) begin
            Tampar = 1'b1;
            @(negedge CK);
            Tampar = 1'b0;
            @(negedge CK);
        end
        applyStimulus(1'b1, 1'b0, "chatter");

        // Simultaneous cap and add; build 1 saturates.
        applyStimulus(1'b1, 1'b1, "both");

        // Caps until build 0 lands on the threshold and auto refills.
        autoSeen = 1'b0;
        for (int i = 0; i < 60 && !autoSeen; i++) applyStimulus(1'b1, 1'b0, "to low");
        checkOutput("auto refill seen", autoSeen, 1);

        // A second count change three cycles into a conversion restarts it.
        for (int d = 0; d < 2; d++) oldB[d] = bcdOf(mCount[d]);
        Tampar = 1'b1;
        repeat (3) @(negedge CK);
        adicionar = 1'b1;
        repeat (3) @(negedge CK);
        @(negedge CK);
        modelStep(1'b1, 1'b0);
        checkState("restart cap");
        for (int k = 8; k <= 18; k++) begin
            @(negedge CK);
            if (k == 8 || k == 11) modelStep(1'b0, 1'b0);
            if (k == 10) begin
                modelStep(1'b0, 1'b1);
                Tampar = 1'b0;
            end
            if (k == 13) adicionar = 1'b0;
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("restart valid k%0d[%0d]", k, d), validS[d], 0);
                checkOutput($sformatf("restart bcd hold k%0d[%0d]", k, d), bcdS[d], oldB[d]);
            end
        end
        @(negedge CK);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("restart final valid[%0d]", d), validS[d], 1);
            checkOutput($sformatf("restart final bcd[%0d]", d), bcdS[d], bcdOf(mCount[d]));
        end
        repeat (10) @(negedge CK);
        checkState("restart settled");
        checkErrs("restart");

        // Random presses.
        repeat (12) begin
            sel = int'($urandom_range(0, 2));
            applyStimulus(sel != 1, sel != 0, "random");
        end

        // Reset in the middle of a conversion.
        Tampar = 1'b1;
        repeat (6) @(negedge CK);
        checkState("midreset pre");
        @(negedge CK);
        modelStep(1'b1, 1'b0);
        @(negedge CK);
        modelStep(1'b0, 1'b0);
        repeat (2) @(negedge CK);
        for (int d = 0; d < 2; d++) checkOutput($sformatf("midreset busy valid[%0d]", d), validS[d], 0);
        ini = 1'b1;
        Tampar = 1'b0;
        @(negedge CK);
        modelReset();
        checkState("midreset");
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("midreset valid[%0d]", d), validS[d], 0);
            checkOutput($sformatf("midreset bcd[%0d]", d), bcdS[d], 0);
        end
        ini = 1'b0;
        checkConv("midreset after");
        checkErrs("midreset");

        // Drain both builds to zero, then cap once more at zero.
        for (int i = 0; i < 130 && (mCount[0] > 0 || mCount[1] > 0); i++) applyStimulus(1'b1, 1'b0, "drain");
        for (int d = 0; d < 2; d++) checkOutput($sformatf("drained[%0d]", d), cntS[d], 0);
        applyStimulus(1'b1, 1'b0, "cap at zero");
        for (int d = 0; d < 2; d++) checkOutput($sformatf("zero TemR[%0d]", d), temrS[d], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
